// File: rtl/portout_arb.sv
// portout_arb: round-robin output-port arbiter feeding an LSB-first serializer.
// Define PORTOUT_PARITY_EN to append an even-parity bit after bit 31.
module portout_arb #(
    parameter int NPORTS = 16,
    parameter logic [3:0] PORT_ID = 4'd0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    vld,
    input  logic [4*NPORTS-1:0]  addr,
    input  logic [32*NPORTS-1:0] payload,
    output logic [NPORTS-1:0]    granted,
    output logic                 dout,
    output logic                 frameo_n,
    output logic                 valido_n,
    output logic                 busy
);
    localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;
`ifdef PORTOUT_PARITY_EN
    localparam logic [5:0] LAST = 6'd32;
`else
    localparam logic [5:0] LAST = 6'd31;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_nx;
    logic [5:0]        cnt, cnt_nx;
    logic [31:0]       sh, sh_nx;
    logic [PW-1:0]     ptr, ptr_nx, win, hi, lo;
    logic              hi_any, lo_any;
    logic [NPORTS-1:0] req, oh, granted_nx;
    logic              dout_nx, frameo_nx, valido_nx;
    logic [31:0]       pl [NPORTS];
`ifdef PORTOUT_PARITY_EN
    logic              par, par_nx;
`endif

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        assign req[i] = vld[i] && addr[4*i +: 4] == PORT_ID;
        assign pl[i]  = payload[32*i +: 32];
    end

    // Prefer the lowest requester above the pointer, else wrap to the lowest one overall.
    always_comb begin
        hi     = '0;
        lo     = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[i[PW-1:0]]) begin
                lo     = i[PW-1:0];
                lo_any = 1'b1;
                if (i > int'(ptr)) begin
                    hi     = i[PW-1:0];
                    hi_any = 1'b1;
                end
            end
        end
        win     = hi_any ? hi : lo;
        oh      = '0;
        oh[win] = 1'b1;
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        sh_nx      = sh;
        ptr_nx     = ptr;
        granted_nx = '0;
        dout_nx    = 1'b0;
        frameo_nx  = 1'b1;
        valido_nx  = 1'b1;
`ifdef PORTOUT_PARITY_EN
        par_nx     = par;
`endif
        if (state == IDLE) begin
            if (lo_any) begin
                state_nx   = SEND;
                sh_nx      = {1'b0, pl[win][31:1]};
                ptr_nx     = win;
                granted_nx = oh;
                dout_nx    = pl[win][0];
                frameo_nx  = 1'b0;
                valido_nx  = 1'b0;
                cnt_nx     = 6'd0;
`ifdef PORTOUT_PARITY_EN
                par_nx     = ^pl[win];
`endif
            end
        end else if (cnt != LAST) begin
            // sh already holds the not-yet-sent bits, next one at bit 0
            cnt_nx    = cnt + 6'd1;
            sh_nx     = {1'b0, sh[31:1]};
            valido_nx = 1'b0;
            frameo_nx = cnt_nx == LAST;
`ifdef PORTOUT_PARITY_EN
            dout_nx   = cnt == 6'd31 ? par : sh[0];
`else
            dout_nx   = sh[0];
`endif
        end else begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            sh       <= 32'd0;
            ptr      <= PW'(NPORTS - 1);
            granted  <= '0;
            dout     <= 1'b0;
            frameo_n <= 1'b1;
            valido_n <= 1'b1;
`ifdef PORTOUT_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            sh       <= sh_nx;
            ptr      <= ptr_nx;
            granted  <= granted_nx;
            dout     <= dout_nx;
            frameo_n <= frameo_nx;
            valido_n <= valido_nx;
`ifdef PORTOUT_PARITY_EN
            par      <= par_nx;
`endif
        end
    end

    assign busy = state == SEND;
endmodule

// File: tb/tb_portout_arb.sv
// tb_portout_arb: randomized scoreboard bench for portout_arb with a packet-level reference model.
module tb_portout_arb;
    localparam int NP = 16;
    localparam logic [3:0] PID = 4'd5;
`ifdef PORTOUT_PARITY_EN
    localparam int NB = 33;
`else
    localparam int NB = 32;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NP-1:0]    vld;
    logic [4*NP-1:0]  addr;
    logic [32*NP-1:0] payload;
    logic [NP-1:0]    granted;
    logic             dout, frameo_n, valido_n, busy;

    logic        pend [NP];
    logic        rr   [NP];
    logic [3:0]  paddr[NP];
    logic [31:0] ppay [NP];

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t expq[$];
    exp_t cur;
    int   glog[$];

    int checks = 0, failures = 0, cyc = 0, frames = 0, nb = 0;
    logic        active = 1'b0, g2seen = 1'b0, lastbit = 1'b0;
    logic [32:0] rx;
    logic [31:0] last_rx = '0;

    portout_arb #(.NPORTS(NP), .PORT_ID(PID)) dut (
        .clock(clock), .reset(reset), .vld(vld), .addr(addr), .payload(payload),
        .granted(granted), .dout(dout), .frameo_n(frameo_n), .valido_n(valido_n), .busy(busy)
    );

    always #5 clock = ~clock;

    // input ports drop vld combinationally while their grant is high
    always_comb begin
        vld = '0;
        addr = '0;
        payload = '0;
        for (int i = 0; i < NP; i++) begin
            vld[i] = pend[i] & ~granted[i];
            addr[4*i +: 4] = paddr[i];
            payload[32*i +: 32] = ppay[i];
        end
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] onehot(input int p);
        return NP'(1) << p;
    endfunction

    // reference model: one packet per arbitration, next arbitration NB+1 edges later
    int mptr = NP - 1, ready = 0;
    always @(posedge clock) begin
        int w;
        logic found;
        cyc++;
        if (reset) begin
            mptr = NP - 1;
            ready = 0;
            expq.delete();
        end else if (cyc >= ready) begin
            found = 1'b0;
            w = 0;
            for (int o = 1; o <= NP; o++) begin
                int j;
                j = (mptr + o) % NP;
                if (!found && pend[j] && paddr[j] == PID) begin
                    found = 1'b1;
                    w = j;
                end
            end
            if (found) begin
                expq.push_back('{w, ppay[w], cyc});
                mptr = w;
                ready = cyc + NB + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            active = 1'b0;
            nb = 0;
        end else begin
            chk("busy", busy, !valido_n);
            if (granted != '0) begin
                for (int i = NP - 1; i >= 0; i--) if (granted[i]) glog.push_back(i);
                if (granted[2]) g2seen = 1'b1;
                chk("grant_overlap", active, 0);
                if (expq.size() == 0) chk("grant_unexpected", granted, 0);
                else begin
                    cur = expq.pop_front();
                    chk("grant_onehot", granted, onehot(cur.port));
                    chk("grant_time", cyc, cur.cyc);
                    active = 1'b1;
                    nb = 0;
                end
            end
            if (!valido_n) begin
                if (!active) chk("stray_bit", valido_n, 1);
                else begin
                    if (nb < 33) rx[nb] = dout;
                    chk("frame_n", frameo_n, nb == NB - 1);
                    nb++;
                    if (frameo_n) begin
                        chk("nbits", nb, NB);
                        chk("payload", rx[31:0], cur.data);
`ifdef PORTOUT_PARITY_EN
                        chk("parity", rx[32], ^cur.data);
`endif
                        lastbit = rx[NB-1];
                        last_rx = rx[31:0];
                        active = 1'b0;
                        frames++;
                    end
                end
            end else begin
                chk("idle_lines", {frameo_n, dout}, 2'b10);
                if (active) begin
                    chk("frame_dropout", nb, NB);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++)
            if (granted[i]) begin
                if (rr[i]) ppay[i] = $urandom;
                else pend[i] = 1'b0;
            end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) begin
            pend[i] = 1'b0;
            rr[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int start = frames;
        int k = 0;
        while (frames < start + n && k < budget) begin
            tick();
            k++;
        end
        chk(name, frames - start, n);
    endtask

    task automatic req(input int p, input logic [3:0] a, input logic [31:0] d);
        paddr[p] = a;
        ppay[p] = d;
        pend[p] = 1'b1;
    endtask

    initial begin
        int k;
        logic busy_left;
        for (int i = 0; i < NP; i++) begin
            pend[i] = 1'b0;
            rr[i] = 1'b0;
            paddr[i] = '0;
            ppay[i] = '0;
        end
        repeat (4) tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_granted", granted, 0);
        chk("rst_frameo", frameo_n, 1);
        chk("rst_valido", valido_n, 1);
        chk("rst_busy", busy, 0);
        repeat (10) tick();

        req(3, PID, 32'hA5A5_0F0F);
        wait_frames(1, 100, "t_single_done");
        chk("t_single_rx", last_rx, 32'hA5A5_0F0F);
        repeat (3) tick();

        do_reset();
        glog.delete();
        foreach (rr[i]) rr[i] = (i == 0 || i == 5 || i == 9);
        req(0, PID, $urandom);
        req(5, PID, $urandom);
        req(9, PID, $urandom);
        k = 0;
        while (glog.size() < 4 && k < 300) begin
            tick();
            k++;
        end
        foreach (rr[i]) begin
            rr[i] = 1'b0;
            pend[i] = 1'b0;
        end
        chk("rr_count", glog.size(), 4);
        chk("rr_0", glog[0], 0);
        chk("rr_1", glog[1], 5);
        chk("rr_2", glog[2], 9);
        chk("rr_3", glog[3], 0);
        repeat (40) tick();

        do_reset();
        glog.delete();
        g2seen = 1'b0;
        req(2, PID ^ 4'd1, $urandom);
        req(7, PID, $urandom);
        wait_frames(1, 100, "t_addr_done");
        repeat (40) tick();
        chk("t_addr_port2", g2seen, 0);
        chk("t_addr_port7", glog.size() > 0 ? glog[0] : -1, 7);
        pend[2] = 1'b0;

        do_reset();
        req(1, PID, $urandom);
        k = 0;
        while (!(active && nb == 10) && k < 100) begin
            tick();
            k++;
        end
        chk("t_rst_reached_bit10", nb, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t_rst_frameo", frameo_n, 1);
        chk("t_rst_valido", valido_n, 1);
        chk("t_rst_busy", busy, 0);
        chk("t_rst_granted", granted, 0);
        repeat (40) tick();

`ifdef PORTOUT_PARITY_EN
        do_reset();
        req(4, PID, 32'h0000_0001);
        wait_frames(1, 100, "t_par1_done");
        chk("t_par1_last", lastbit, 1);
        req(4, PID, 32'h0000_0003);
        wait_frames(1, 100, "t_par3_done");
        chk("t_par3_last", lastbit, 0);
`endif

        do_reset();
        repeat (3000) begin
            tick();
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && $urandom_range(0, 15) == 0)
                    req(i, $urandom_range(0, 1) != 0 ? PID : 4'($urandom), $urandom);
                else if (pend[i] && paddr[i] != PID && $urandom_range(0, 7) == 0)
                    pend[i] = 1'b0;
            end
        end
        k = 0;
        busy_left = 1'b1;
        while (busy_left && k < 2000) begin
            tick();
            k++;
            busy_left = active || expq.size() != 0;
            for (int i = 0; i < NP; i++) if (pend[i] && paddr[i] == PID) busy_left = 1'b1;
        end
        chk("drain", busy_left, 0);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
